// File: rtl/axi_master.sv
// axi_master: single-outstanding AXI3 burst master bridging a simple
// command / write-stream / read-stream user interface onto M_AXI_GP0.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN; without it
// the block waits indefinitely on the slave and timeout_err is tied low.
module axi_master #(
    parameter logic [11:0] AXI_ID         = 12'h000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETN,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,

    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,

    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    input  logic        rd_ready,

    output logic        done,
    output logic [1:0]  resp,
    output logic        timeout_err,

    output logic [31:0] M_AXI_GP0_awaddr,
    output logic [3:0]  M_AXI_GP0_awlen,
    output logic [11:0] M_AXI_GP0_awid,
    output logic [2:0]  M_AXI_GP0_awsize,
    output logic [1:0]  M_AXI_GP0_awburst,
    output logic [3:0]  M_AXI_GP0_awcache,
    output logic [1:0]  M_AXI_GP0_awlock,
    output logic [2:0]  M_AXI_GP0_awprot,
    output logic [3:0]  M_AXI_GP0_awqos,
    output logic        M_AXI_GP0_awvalid,
    input  logic        M_AXI_GP0_awready,

    output logic [31:0] M_AXI_GP0_wdata,
    output logic [3:0]  M_AXI_GP0_wstrb,
    output logic [11:0] M_AXI_GP0_wid,
    output logic        M_AXI_GP0_wlast,
    output logic        M_AXI_GP0_wvalid,
    input  logic        M_AXI_GP0_wready,

    input  logic [11:0] M_AXI_GP0_bid,
    input  logic [1:0]  M_AXI_GP0_bresp,
    input  logic        M_AXI_GP0_bvalid,
    output logic        M_AXI_GP0_bready,

    output logic [31:0] M_AXI_GP0_araddr,
    output logic [3:0]  M_AXI_GP0_arlen,
    output logic [11:0] M_AXI_GP0_arid,
    output logic [2:0]  M_AXI_GP0_arsize,
    output logic [1:0]  M_AXI_GP0_arburst,
    output logic [3:0]  M_AXI_GP0_arcache,
    output logic [1:0]  M_AXI_GP0_arlock,
    output logic [2:0]  M_AXI_GP0_arprot,
    output logic [3:0]  M_AXI_GP0_arqos,
    output logic        M_AXI_GP0_arvalid,
    input  logic        M_AXI_GP0_arready,

    input  logic [31:0] M_AXI_GP0_rdata,
    input  logic [11:0] M_AXI_GP0_rid,
    input  logic [1:0]  M_AXI_GP0_rresp,
    input  logic        M_AXI_GP0_rlast,
    input  logic        M_AXI_GP0_rvalid,
    output logic        M_AXI_GP0_rready
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WADDR = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_WRESP = 3'd3;
    localparam logic [2:0] ST_RADDR = 3'd4;
    localparam logic [2:0] ST_RDATA = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [2:0] AXI_SIZE_4B  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE    = 4'b0011;
    localparam logic [1:0] AXI_LOCK     = 2'b00;
    localparam logic [2:0] AXI_PROT     = 3'b000;
    localparam logic [3:0] AXI_QOS      = 4'h0;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    logic [2:0]  state;
    logic [2:0]  normal_next;
    logic [2:0]  next_state;
    logic        cmd_ready_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_cnt;
    logic [1:0]  resp_q;

    logic        accept;
    logic        active;
    logic        w_beat;
    logic        r_beat;
    logic        wd_expired;
    logic        timeout_hit;

    // Response IDs are deliberately ignored; only one transaction is ever in flight.
    logic        unused_ids;
    assign unused_ids = ^{M_AXI_GP0_bid, M_AXI_GP0_rid};

    assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign active = (state == ST_WADDR) || (state == ST_WDATA) || (state == ST_WRESP) ||
                    (state == ST_RADDR) || (state == ST_RDATA);
    assign w_beat = (state == ST_WDATA) && wr_valid && M_AXI_GP0_wready;
    assign r_beat = (state == ST_RDATA) && M_AXI_GP0_rvalid && rd_ready;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_err_q;

    assign wd_expired = active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts cycles spent in one waiting state and restarts on every state change.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wd_cnt <= '0;
        end else if (state != next_state) begin
            wd_cnt <= '0;
        end else if (active) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only when the next command is accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            timeout_err_q <= 1'b0;
        end else if (accept) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic; a watchdog expiry only wins when no handshake is moving the FSM this cycle.
    always_comb begin
        normal_next = state;
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    normal_next = cmd_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (M_AXI_GP0_awready) begin
                    normal_next = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (w_beat && (beat_cnt == len_q)) begin
                    normal_next = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (M_AXI_GP0_bvalid) begin
                    normal_next = ST_DONE;
                end
            end
            ST_RADDR: begin
                if (M_AXI_GP0_arready) begin
                    normal_next = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_beat && M_AXI_GP0_rlast) begin
                    normal_next = ST_DONE;
                end
            end
            ST_DONE: begin
                normal_next = ST_IDLE;
            end
            default: begin
                normal_next = ST_IDLE;
            end
        endcase
        next_state = normal_next;
        if (wd_expired && (normal_next == state)) begin
            next_state  = ST_DONE;
            timeout_hit = 1'b1;
        end
    end

    // State register; cmd_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b0;
        end else begin
            state       <= next_state;
            cmd_ready_q <= (next_state == ST_IDLE);
        end
    end

    // Command capture, write beat counting and response accumulation (worst rresp wins on reads).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            resp_q   <= '0;
        end else if (accept) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            resp_q   <= '0;
        end else if (timeout_hit) begin
            resp_q   <= RESP_SLVERR;
        end else begin
            if (w_beat) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
            if ((state == ST_WRESP) && M_AXI_GP0_bvalid) begin
                resp_q <= M_AXI_GP0_bresp;
            end
            if (r_beat && (M_AXI_GP0_rresp > resp_q)) begin
                resp_q <= M_AXI_GP0_rresp;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = (state == ST_DONE);
    assign resp      = resp_q;

    assign M_AXI_GP0_awaddr  = addr_q;
    assign M_AXI_GP0_awlen   = len_q;
    assign M_AXI_GP0_awid    = AXI_ID;
    assign M_AXI_GP0_awsize  = AXI_SIZE_4B;
    assign M_AXI_GP0_awburst = AXI_BURST_INCR;
    assign M_AXI_GP0_awcache = AXI_CACHE;
    assign M_AXI_GP0_awlock  = AXI_LOCK;
    assign M_AXI_GP0_awprot  = AXI_PROT;
    assign M_AXI_GP0_awqos   = AXI_QOS;
    assign M_AXI_GP0_awvalid = (state == ST_WADDR);

    assign M_AXI_GP0_wdata   = wr_data;
    assign M_AXI_GP0_wstrb   = 4'hF;
    assign M_AXI_GP0_wid     = AXI_ID;
    assign M_AXI_GP0_wlast   = (state == ST_WDATA) && (beat_cnt == len_q);
    assign M_AXI_GP0_wvalid  = (state == ST_WDATA) && wr_valid;
    assign wr_ready          = (state == ST_WDATA) && M_AXI_GP0_wready;

    assign M_AXI_GP0_bready  = (state == ST_WRESP);

    assign M_AXI_GP0_araddr  = addr_q;
    assign M_AXI_GP0_arlen   = len_q;
    assign M_AXI_GP0_arid    = AXI_ID;
    assign M_AXI_GP0_arsize  = AXI_SIZE_4B;
    assign M_AXI_GP0_arburst = AXI_BURST_INCR;
    assign M_AXI_GP0_arcache = AXI_CACHE;
    assign M_AXI_GP0_arlock  = AXI_LOCK;
    assign M_AXI_GP0_arprot  = AXI_PROT;
    assign M_AXI_GP0_arqos   = AXI_QOS;
    assign M_AXI_GP0_arvalid = (state == ST_RADDR);

    assign M_AXI_GP0_rready  = (state == ST_RDATA) && rd_ready;
    assign rd_valid          = (state == ST_RDATA) && M_AXI_GP0_rvalid;
    assign rd_data           = M_AXI_GP0_rdata;
    assign rd_last           = (state == ST_RDATA) && M_AXI_GP0_rlast;

endmodule
